// File: rtl/mem_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : mips_mem_pkg
// Desc   : Shared types for the instruction/data memory port arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_mem_pkg;

  localparam int c_STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : mem_port_arbiter_if
// Desc   : Fetch, data and memory-side signals of the shared memory port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // The arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  // The requester/memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_starve_ctr.sv
//------------------------------------------------------------------------------
// Module : arb_starve_ctr
// Desc   : Saturating count of data grants made while a fetch is waiting.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_starve_ctr
  import mips_mem_pkg::*;
#(
  parameter int MAX_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [c_STARVE_W-1:0] c_MAX = c_STARVE_W'(MAX_VAL);

  logic [c_STARVE_W-1:0] r_count;

  assign o_at_max = (r_count >= c_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_port_arbiter
// Desc   : Shares one memory port between fetch and data; data has priority,
//          bounded by a starvation counter that guarantees fetch progress.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               busy,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  owner_t            r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_grant_i;
  logic w_grant_d;
  logic w_at_max;
  logic w_starve_inc;
  logic w_starve_clr;
  logic w_in_access;

  assign w_in_access  = (r_state == I_BUSY) || (r_state == D_BUSY);
  assign w_starve_inc = w_grant_d & bus.i_req;
  assign w_starve_clr = w_grant_i | (w_grant_d & ~bus.i_req);

  arb_starve_ctr #(
    .MAX_VAL (STARVE_MAX)
  ) u_starve (
    .clk      (clock),
    .rst      (reset),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_at_max)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          // Data wins unless a waiting fetch has already been passed over STARVE_MAX times
          if (bus.d_req && (!bus.i_req || !w_at_max)) begin
            w_grant_d   = 1'b1;
            w_state_nxt = D_BUSY;
          end else if (bus.i_req) begin
            w_grant_i   = 1'b1;
            w_state_nxt = I_BUSY;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_ack) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= OWN_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_d) begin
        r_owner <= OWN_D;
        r_we    <= bus.d_we;
        r_addr  <= bus.d_addr;
        r_wdata <= bus.d_wdata;
      end else if (w_grant_i) begin
        r_owner <= OWN_I;
        r_we    <= 1'b0;
        r_addr  <= bus.i_addr;
        r_wdata <= bus.d_wdata;
      end
      if (w_in_access && bus.mem_ack) begin
        if (r_state == D_BUSY) begin
          r_d_rdata <= bus.mem_rdata;
        end else begin
          r_i_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_req   = w_in_access;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.i_ready   = (r_state == RESP) && (r_owner == OWN_I);
  assign bus.d_ready   = (r_state == RESP) && (r_owner == OWN_D);
  assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_mem_port_arbiter
// Desc   : Randomized bench for mem_port_arbiter with a transaction-level model
//          and a ready/rdata scoreboard.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {P_FREE, P_IBUSY, P_DBUSY, P_RESP} mphase_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          due;
  } resp_t;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic busy;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .busy   (busy),
    .bus    (bus.slave)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  resp_t sb[$];

  // Transaction-level model: an access is one grant cycle, busy until ack, one response cycle
  mphase_t     ph        = P_FREE;
  bit          m_own_d   = 1'b0;
  int          starve    = 0;
  int          wait_left = 0;
  logic [31:0] e_addr    = '0;
  logic [31:0] e_wdata   = '0;
  logic [31:0] e_irdata  = '0;
  logic [31:0] e_drdata  = '0;
  bit          e_we      = 1'b0;
  bit          prev_rst  = 1'b1;
  bit          prev_req  = 1'b0;
  string       dut_grants = "";

  // Requesters: fetch addresses have bit 31 clear, data addresses have it set
  bit          f_pend = 1'b0;
  bit          d_pend = 1'b0;
  logic [31:0] f_addr = '0;
  logic [31:0] dq_addr = '0;
  logic [31:0] dq_wdata = '0;
  bit          dq_we = 1'b0;

  int          arrival_pct = 0;
  int          wait_max    = 0;
  int          noise_pct   = 0;
  int          force_wait  = -1;
  bit          force_rd_v  = 1'b0;
  logic [31:0] force_rd    = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic new_fetch();
    f_pend = 1'b1;
    f_addr = $urandom & 32'h7FFF_FFFC;
  endtask

  task automatic new_data();
    d_pend   = 1'b1;
    dq_we    = 1'($urandom_range(0, 1));
    dq_addr  = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
    dq_wdata = $urandom;
  endtask

  task automatic run_cycle(input bit rst_v, input bit en_v);
    bit          ack;
    bit          iq;
    bit          dq;
    logic [31:0] rd;
    @(negedge clock);
    cyc++;

    chk("mem_req", 32'(bus.mem_req), 32'(ph == P_IBUSY || ph == P_DBUSY));
    chk("busy", 32'(busy), 32'(ph != P_FREE));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (ph == P_DBUSY) chk("mem_wdata", bus.mem_wdata, e_wdata);
    if (prev_rst) chk("mem_wdata after reset", bus.mem_wdata, 32'h0);
    chk("i_rdata", bus.i_rdata, e_irdata);
    chk("d_rdata", bus.d_rdata, e_drdata);
    if (bus.mem_req && !prev_req) begin
      if (bus.mem_addr[31]) dut_grants = {dut_grants, "D"};
      else                  dut_grants = {dut_grants, "I"};
    end
    prev_req = bus.mem_req;
    prev_rst = rst_v;

    if (!f_pend && $urandom_range(0, 99) < arrival_pct) new_fetch();
    if (!d_pend && $urandom_range(0, 99) < arrival_pct) new_data();
    iq = f_pend;
    dq = d_pend;
    bus.i_addr  = f_addr;
    bus.d_addr  = dq_addr;
    bus.d_we    = dq_we;
    bus.d_wdata = dq_wdata;
    // The owner's inputs are don't-care while its access is in flight
    if (ph != P_FREE) begin
      if (m_own_d) begin
        dq          = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_wdata = $urandom;
      end else begin
        iq         = 1'($urandom_range(0, 1));
        bus.i_addr = $urandom;
      end
    end

    rd = $urandom;
    if (ph == P_IBUSY || ph == P_DBUSY) begin
      ack = (wait_left == 0);
      if (ack && force_rd_v) rd = force_rd;
    end else begin
      ack = ($urandom_range(0, 99) < noise_pct);
    end

    reset         = rst_v;
    enable        = en_v;
    bus.i_req     = iq;
    bus.d_req     = dq;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;

    if (ph == P_RESP) begin
      if (m_own_d) d_pend = 1'b0;
      else         f_pend = 1'b0;
    end
    if (rst_v) begin
      ph = P_FREE; starve = 0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
      e_irdata = '0; e_drdata = '0;
    end else begin
      case (ph)
        P_FREE: begin
          if (en_v && dq && (!iq || starve < STARVE_MAX)) begin
            ph = P_DBUSY; m_own_d = 1'b1;
            starve = iq ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
            e_addr = dq_addr; e_we = dq_we; e_wdata = dq_wdata;
            wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, wait_max);
          end else if (en_v && iq) begin
            ph = P_IBUSY; m_own_d = 1'b0; starve = 0;
            e_addr = f_addr; e_we = 1'b0;
            wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, wait_max);
          end
        end
        P_IBUSY, P_DBUSY: begin
          if (ack) begin
            ph = P_RESP;
            sb.push_back('{is_d: m_own_d, rdata: rd, due: cyc + 1});
            if (m_own_d) e_drdata = rd;
            else         e_irdata = rd;
          end else begin
            wait_left--;
          end
        end
        default: ph = P_FREE;
      endcase
    end
  endtask

  // Scoreboard monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clock);
      #1;
      if (bus.i_ready && bus.d_ready) begin
        n_tests++; n_fail++;
        $display("FAIL both readies: i_ready=1 d_ready=1 expected at most one (cycle %0d)", cyc);
      end
      if (bus.i_ready || bus.d_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected ready: i_ready=%0b d_ready=%0b expected none (cycle %0d)",
                   bus.i_ready, bus.d_ready, cyc);
        end else begin
          r = sb.pop_front();
          chk("ready owner (d_ready)", 32'(bus.d_ready), 32'(r.is_d));
          chk("ready cycle", 32'(cyc), 32'(r.due));
          chk("ready rdata", bus.d_ready ? bus.d_rdata : bus.i_rdata, r.rdata);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_tests++; n_fail++;
        $display("FAIL missing ready: got none expected %s ready at cycle %0d",
                 sb[0].is_d ? "d" : "i", sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;

    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);

    // Single fetch, ack in the first busy cycle
    f_pend = 1'b1; f_addr = 32'h0040_0000;
    force_wait = 0; force_rd_v = 1'b1; force_rd = 32'h2008_0005;
    repeat (5) run_cycle(1'b0, 1'b1);
    force_rd_v = 1'b0;

    // Store with three wait cycles
    d_pend = 1'b1; dq_we = 1'b1; dq_addr = 32'h1001_0000; dq_wdata = 32'hDEAD_BEEF;
    force_wait = 3;
    repeat (8) run_cycle(1'b0, 1'b1);

    // Both requesters held continuously
    force_wait = 0; arrival_pct = 100; dut_grants = "";
    for (int k = 0; k < 200 && dut_grants.len() < 10; k++) run_cycle(1'b0, 1'b1);
    n_tests++;
    if (dut_grants != "DDDDIDDDDI") begin
      n_fail++;
      $display("FAIL grant order: got %s expected DDDDIDDDDI", dut_grants);
    end

    // Enable low with requests pending, then released
    repeat (6) run_cycle(1'b0, 1'b0);
    repeat (4) run_cycle(1'b0, 1'b1);

    // Reset in the middle of a data access
    arrival_pct = 0; force_wait = 6;
    if (!d_pend) new_data();
    for (int k = 0; k < 60 && ph != P_DBUSY; k++) run_cycle(1'b0, 1'b1);
    n_tests++;
    if (ph != P_DBUSY) begin
      n_fail++;
      $display("FAIL reach D_BUSY: got timeout expected data access within 60 cycles");
    end
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b1, 1'b1);
    force_wait = -1;
    repeat (12) run_cycle(1'b0, 1'b1);

    // Random traffic with waits, stray acks, enable gaps and occasional resets
    arrival_pct = 30; wait_max = 3; noise_pct = 20;
    repeat (3000) run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85);

    arrival_pct = 0; noise_pct = 0;
    for (int k = 0; k < 200 && (f_pend || d_pend || ph != P_FREE); k++) run_cycle(1'b0, 1'b1);
    repeat (3) run_cycle(1'b0, 1'b1);
    #2;
    chk("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the CPU's single memory port between instruction fetch and data load/store. It sits between the pipeline's fetch and memory stages and the unified memory model instantiated under `top`. Data accesses have fixed priority over fetches, and a starvation counter guarantees fetch progress. The block gates new grants on `enable`, so the testbench's `start`/`enable` sequencing controls when the CPU first touches memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while `i_req` is pending; range 1..15

Ports:
- clock  in  1  single system clock; all logic is rising-edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of `clock`
- enable  in  1  permits new grants; an in-flight access always completes
- i_req  in  1  fetch request, level; held until `i_ready`
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch data; valid when `i_ready` is high
- i_ready  out  1  one-cycle completion pulse for a fetch
- d_req  in  1  data request, level; held until `d_ready`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when `d_ready` is high
- d_ready  out  1  one-cycle completion pulse for a data access
- mem_req  out  1  memory request; held until `mem_ack`
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid when `mem_ack` is high
- mem_ack  in  1  memory completion; may arrive any number of cycles after `mem_req`
- busy  out  1  high in every state other than IDLE

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE, with `enable` high:
  - If `d_req` is high and either `i_req` is low or the starvation count is below STARVE_MAX, go to D_BUSY.
  - Otherwise, if `i_req` is high, go to I_BUSY.
  - With `enable` low, stay in IDLE.
- On grant: latch the address, the write strobe (forced to 0 for fetches), the write data, and the owner into transaction registers. The `mem_*` outputs are driven only from these registers.
- I_BUSY / D_BUSY:
  - `mem_req` is high.
  - When `mem_ack` is high, capture `mem_rdata` into the response register and go to RESP.
- RESP:
  - Assert the owner's `*_ready` for exactly one cycle; its `*_rdata` shows the captured word.
  - For a store, `d_rdata` shows whatever `mem_rdata` was at the ack.
  - Then go to IDLE.
- Starvation count (4 bits):
  - Increments on a data grant made while `i_req` is high.
  - Clears on any fetch grant.
  - Clears on a data grant made while `i_req` is low.
  - Saturates at STARVE_MAX.
- `mem_ack` is ignored in IDLE and RESP.
- Requester inputs are ignored outside IDLE; a request dropped mid-access still completes and still pulses its ready.
- When not selected, `i_rdata` and `d_rdata` hold their last value; `*_ready` is 0.

## Timing
- Reset values: `mem_req`, `mem_we`, `i_ready`, `d_ready`, `busy` = 0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0; state = IDLE; starvation count = 0.
- Reset asserted mid-access returns to IDLE on the next edge. `mem_req` drops at that edge, and no ready pulse is issued.
- Minimum latency is 3 cycles. With a request in IDLE at cycle 0 and `mem_ack` in cycle 1, the ready pulse is in cycle 2.
- Each added wait cycle before `mem_ack` adds one cycle of latency.
- The requester updates its request at the edge that ends the RESP cycle; the updated request is arbitrated in the following IDLE cycle.
- Back-to-back throughput: one access per 3 cycles plus memory waits.
- Simultaneous `i_req` and `d_req` with count < STARVE_MAX: the data access wins.

## Structure
- Shared package `mips_mem_pkg`:
  - `arb_state_t` enum (IDLE, I_BUSY, D_BUSY, RESP)
  - `owner_t` (OWN_I, OWN_D)
  - localparam for the starvation counter width
- One natural sub-module: `arb_starve_ctr`, the saturating counter with increment and clear inputs and an `at_max` output.
- Everything else stays in one always block for the FSM plus the transaction registers.

## Test plan
- Reset, then a single fetch: `i_req` with `i_addr=0x00400000`, `mem_ack` in the first BUSY cycle with `mem_rdata=0x20080005` → `i_ready` high for exactly one cycle at cycle 2 with `i_rdata=0x20080005`; `mem_we=0` throughout.
- Store with 3 wait cycles: `d_we=1`, `d_addr=0x10010000`, `d_wdata=0xDEADBEEF` → `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` held stable for 4 cycles; `d_ready` pulses one cycle after `mem_ack`.
- Simultaneous `i_req` and `d_req`, both held continuously, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I…
- `enable=0` while requests are pending → no `mem_req`; raising `enable` → grant on the next IDLE cycle.
- Reset pulsed during D_BUSY → `mem_req=0` and `busy=0` after the edge; no `d_ready`; the next grant behaves exactly as after power-on.
- `mem_ack` pulsed in IDLE and in RESP → ignored; no state change and no extra ready pulse.
